// File: rtl/store_issue_if.sv
// Pipeline/bus bundle for the M-stage store issue unit.
// Valid/ready: a store is offered with st_valid and taken only when stall=0 and exc_ades=0; a bus write completes on the cycle bus_req && bus_ack.
interface store_issue_if;
  logic        st_valid;
  logic [1:0]  st_type;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        flush;
  logic        stall;
  logic        exc_ades;
  logic        exc_buserr;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata_raw;
  logic        bus_ack;

  // master: pipeline plus bus environment; slave: the store issue unit
  modport master (
    output st_valid, st_type, st_addr, st_data, flush, bus_ack,
    input  stall, exc_ades, exc_buserr, bus_req, bus_addr, bus_byteen, bus_wdata_raw
  );

  modport slave (
    input  st_valid, st_type, st_addr, st_data, flush, bus_ack,
    output stall, exc_ades, exc_buserr, bus_req, bus_addr, bus_byteen, bus_wdata_raw
  );
endinterface

// File: rtl/store_issue_unit.sv
// Single-entry M-stage store buffer: byte-enable generation, alignment/range
// checking, and holding one store on the bus until ack or timeout.
module store_issue_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  store_issue_if.slave  sif,
  output logic          dbg_state_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   data_q, data_d;
  logic          buserr_q, buserr_d;

  logic [3:0]    byteen;
  logic          considered, misalign, in_dm, in_t0, in_t1, ro_hit, ades_c;
  logic          stall_c;

  always_comb begin
    byteen = 4'b0000;
    case (sif.st_type)
      2'b01:   byteen = 4'b0001 << sif.st_addr[1:0];
      2'b10:   byteen = sif.st_addr[1] ? 4'b1100 : 4'b0011;
      2'b11:   byteen = 4'b1111;
      default: byteen = 4'b0000;
    endcase
  end

  // Only the DM window and the two timer blocks are mapped; timer blocks take
  // aligned word writes only, and their count registers are read-only.
  assign considered = reset && sif.st_valid && (sif.st_type != 2'b00) && !sif.flush;
  assign misalign   = ((sif.st_type == 2'b11) && (sif.st_addr[1:0] != 2'b00)) ||
                      ((sif.st_type == 2'b10) && sif.st_addr[0]);
  assign in_dm      = (sif.st_addr <= 32'h0000_2FFF);
  assign in_t0      = (sif.st_addr >= 32'h0000_7F00) && (sif.st_addr <= 32'h0000_7F0B);
  assign in_t1      = (sif.st_addr >= 32'h0000_7F10) && (sif.st_addr <= 32'h0000_7F1B);
  assign ro_hit     = (sif.st_addr == 32'h0000_7F08) || (sif.st_addr == 32'h0000_7F18);
  assign ades_c     = considered &&
                      (misalign || !(in_dm || in_t0 || in_t1) ||
                       ((in_t0 || in_t1) && (sif.st_type != 2'b11)) || ro_hit);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    be_d     = be_q;
    data_d   = data_q;
    buserr_d = 1'b0;
    stall_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (considered && !ades_c) begin
          state_d = BUSY;
          cnt_d   = '0;
          addr_d  = sif.st_addr;
          be_d    = byteen;
          data_d  = sif.st_data;
        end
      end
      BUSY: begin
        // No bypass: a store waiting behind the entry stalls through the ack cycle.
        stall_c = sif.st_valid && (sif.st_type != 2'b00) && !ades_c;
        if (sif.bus_ack) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = IDLE;
          cnt_d    = '0;
          buserr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      data_q   <= '0;
      buserr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      data_q   <= data_d;
      buserr_q <= buserr_d;
    end
  end

  assign sif.stall         = reset && stall_c;
  assign sif.exc_ades      = ades_c;
  assign sif.exc_buserr    = buserr_q;
  assign sif.bus_req       = (state_q == BUSY);
  assign sif.bus_addr      = addr_q;
  assign sif.bus_byteen    = be_q;
  assign sif.bus_wdata_raw = data_q;
  assign dbg_state_o       = (state_q == BUSY);

endmodule

// File: tb/tb_store_issue_unit.sv
// Randomized bench for store_issue_unit: reference model of the address map
// and byte enables, expected bus completions queued and checked by a monitor.
module tb_store_issue_unit;
  localparam int unsigned TO = 4;
  localparam int W = 69;  // {timeout, addr, byteen, data}

  logic clk = 1'b0;
  logic reset;
  logic dbg_busy;
  store_issue_if sif();

  store_issue_unit #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .sif         (sif.slave),
    .dbg_state_o (dbg_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Legal store targets: any byte below 0x3000 for sb, even below 0x3000 for sh,
  // and for sw an aligned DM word or one of the writable timer words.
  function automatic bit model_legal(input logic [1:0] t, input logic [31:0] a);
    bit in_dm;
    in_dm = (a < 32'h3000);
    case (t)
      2'b01:   return in_dm;
      2'b10:   return in_dm && (a % 2 == 0);
      2'b11:   return (a % 4 == 0) &&
                      (in_dm || (a inside {32'h7F00, 32'h7F04, 32'h7F10, 32'h7F14}));
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit model_ades(input bit v, input logic [1:0] t, input logic [31:0] a, input bit f);
    return v && (t != 2'b00) && !f && !model_legal(t, a);
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] t, input logic [31:0] a);
    case (t)
      2'b01:   return 4'(1 << (a % 4));
      2'b10:   return 4'(3 << (a % 4));
      2'b11:   return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 3))
      0, 1:    return 32'($urandom_range(0, 32'h2FFF));
      2:       return 32'h7F00 + 32'($urandom_range(0, 32'h1F));
      default: return $urandom();
    endcase
  endfunction

  task automatic drive(input bit v, input logic [1:0] t, input logic [31:0] a, input logic [31:0] d, input bit f);
    sif.st_valid = v;
    sif.st_type  = t;
    sif.st_addr  = a;
    sif.st_data  = d;
    sif.flush    = f;
  endtask

  task automatic drive_idle();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
  endtask

  // bg: 0 nothing behind, 1 random request, 2 legal sw waiting, 3 legal sw under flush
  task automatic do_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                          input bit f, input int ack_at, input int bg);
    bit ades, acc, exp_stall;
    logic [W-1:0] e;
    ades = model_ades(1'b1, t, a, f);
    acc  = (t != 2'b00) && !f && !ades;
    e    = {((ack_at > int'(TO)) ? 1'b1 : 1'b0), a, model_be(t, a), d};
    drive(1'b1, t, a, d, f);
    sif.bus_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("idle_ades", W'(sif.exc_ades), W'(ades));
    chk("idle_stall", W'(sif.stall), W'(0));
    chk("idle_req", W'(sif.bus_req), W'(0));
    if (acc) exp_q.push_back(e);
    @(posedge clk); #1;
    drive_idle();
    sif.bus_ack = 1'b0;
    if (!acc) begin
      @(negedge clk);
      chk("no_accept_req", W'(sif.bus_req), W'(0));
      @(posedge clk); #1;
      return;
    end
    for (int k = 1; k <= int'(TO); k++) begin
      sif.bus_ack = (k == ack_at);
      if (bg == 2 || bg == 3)
        drive(1'b1, 2'b11, 32'h200, $urandom(), bg == 3);
      else if (bg == 1 && $urandom_range(0, 1) == 1)
        drive(1'b1, 2'($urandom_range(0, 3)), rand_addr(), $urandom(), $urandom_range(0, 3) == 0);
      else
        drive_idle();
      exp_stall = sif.st_valid && (sif.st_type != 2'b00) &&
                  !model_ades(sif.st_valid, sif.st_type, sif.st_addr, sif.flush);
      @(negedge clk);
      chk("busy_req", W'(sif.bus_req), W'(1));
      chk("busy_dbg", W'(dbg_busy), W'(1));
      chk("busy_hold", W'({sif.bus_addr, sif.bus_byteen, sif.bus_wdata_raw}), W'(e[67:0]));
      chk("busy_stall", W'(sif.stall), W'(exp_stall));
      chk("busy_ades", W'(sif.exc_ades),
          W'(model_ades(sif.st_valid, sif.st_type, sif.st_addr, sif.flush)));
      @(posedge clk); #1;
      if (k == ack_at) break;
    end
    drive_idle();
    sif.bus_ack = 1'b0;
    @(negedge clk);
    chk("post_req", W'(sif.bus_req), W'(0));
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string name);
    chk(name, W'({sif.stall, sif.exc_ades, sif.exc_buserr, sif.bus_req, sif.bus_addr,
                  sif.bus_byteen, sif.bus_wdata_raw, dbg_busy}), W'(0));
  endtask

  // Completions and timeouts each retire one queued expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (sif.bus_req && sif.bus_ack) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL bus_write: got write %0h with no store expected", sif.bus_addr);
        end else begin
          mon_e = exp_q.pop_front();
          chk("bus_write", {1'b0, sif.bus_addr, sif.bus_byteen, sif.bus_wdata_raw}, mon_e);
        end
      end
      if (sif.exc_buserr) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL bus_timeout: got exc_buserr=1 expected 0");
        end else begin
          mon_e = exp_q.pop_front();
          chk("bus_timeout", {1'b1, sif.bus_addr, sif.bus_byteen, sif.bus_wdata_raw}, mon_e);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    drive_idle();
    sif.bus_ack = 1'b0;
    #12;
    check_all_zero("reset_state");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    do_store(2'b11, 32'h0000_0104, 32'hDEAD_BEEF, 1'b0, 2, 0);
    do_store(2'b01, 32'h0000_0013, 32'h1122_3344, 1'b0, 2, 0);
    do_store(2'b10, 32'h0000_0012, 32'h5566_7788, 1'b0, 3, 2);
    do_store(2'b10, 32'h0000_0010, 32'h99AA_BBCC, 1'b0, 1, 2);

    do_store(2'b11, 32'h0000_0102, 32'h1, 1'b0, 1, 0);
    do_store(2'b10, 32'h0000_0101, 32'h2, 1'b0, 1, 0);
    do_store(2'b11, 32'h0000_3000, 32'h3, 1'b0, 1, 0);
    do_store(2'b01, 32'h0000_7F00, 32'h4, 1'b0, 1, 0);
    do_store(2'b11, 32'h0000_7F08, 32'h5, 1'b0, 1, 0);
    do_store(2'b11, 32'h0000_7F18, 32'h6, 1'b0, 1, 0);

    do_store(2'b11, 32'h0000_7F10, 32'hCAFE_0001, 1'b0, int'(TO) + 1, 0);
    do_store(2'b11, 32'h0000_7F10, 32'hCAFE_0002, 1'b0, int'(TO), 0);

    do_store(2'b11, 32'h0000_0200, 32'hF00D_0001, 1'b1, 1, 0);
    do_store(2'b11, 32'h0000_0204, 32'hF00D_0002, 1'b0, 3, 3);

    // Asynchronous reset while a store is outstanding: it must be dropped.
    drive(1'b1, 2'b11, 32'h0000_0300, 32'h0BAD_0BAD, 1'b0);
    @(posedge clk); #1;
    exp_q.delete();
    drive(1'b1, 2'b11, 32'h0000_3000, 32'h0, 1'b0);
    #2 reset = 1'b0;
    #1 check_all_zero("reset_mid_busy");
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_no_reissue", W'(sif.bus_req), W'(0));
    end
    @(posedge clk); #1;

    for (int n = 0; n < 150; n++)
      do_store(2'($urandom_range(0, 3)), rand_addr(), $urandom(), $urandom_range(0, 7) == 0,
               int'($urandom_range(1, TO + 1)), 1);

    repeat (2) @(posedge clk);
    chk("queue_drained", W'(exp_q.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
